// File: rtl/serial_rx_pkg.sv
// Shared constants for the 8N1 UART receiver: state codes, oversample
// sample points and the 3-sample majority helper.
package serial_rx_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_START = 3'd1;
   localparam state_t ST_DATA  = 3'd2;
   localparam state_t ST_STOP  = 3'd3;
   localparam state_t ST_BREAK = 3'd4;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] VOTE_S0    = 4'd7;
   localparam logic [3:0] VOTE_S1    = 4'd8;
   localparam logic [3:0] VOTE_S2    = 4'd9;
   localparam logic [3:0] LAST_S     = 4'd15;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/serial_rx_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks. clr restarts
// the count so ticks line up with the detected start edge.
module serial_rx_baud_tick #(
   parameter int DIV = 326
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // divider counter, wraps at DIV-1 or restarts on clr
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver with 16x oversampling and a 3-sample majority vote
// around mid-bit. Good bytes are presented on rx_data with a one-clock
// rx_valid strobe; a zero stop bit sets the sticky frame_err.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge on rxs
// ST_START | qualifying the start bit (false start if it votes high)
// ST_DATA  | shifting in 8 data bits, LSB first
// ST_STOP  | sampling the stop bit; decides good byte vs framing error
// ST_BREAK | stop bit was low; wait for the line to return high
module serial_rx
   import serial_rx_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600,
   parameter int DIV      = (CLK_FREQ + BAUD * (OVERSAMPLE / 2)) / (BAUD * OVERSAMPLE)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_err
);

   logic       sync1;
   logic       rxs;
   state_t     state;
   state_t     state_nx;
   logic [3:0] s;
   logic [2:0] b;
   logic [1:0] smp;
   logic [7:0] shreg;
   logic       tick;
   logic       clr;
   logic       vote;
   logic       at_vote;
   logic       at_last;

   serial_rx_baud_tick #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .tick  (tick)
   );

   // two-flop synchronizer for the asynchronous serial line
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rx_in;
         rxs   <= sync1;
      end
   end

   assign clr     = (state == ST_IDLE) && !rxs;
   assign vote    = majority3(smp[0], smp[1], rxs);
   assign at_vote = tick && (s == VOTE_S2);
   assign at_last = tick && (s == LAST_S);

   // next-state decision
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (!rxs) state_nx = ST_START;
         ST_START: begin
            if (at_vote && vote) state_nx = ST_IDLE;
            else if (at_last)    state_nx = ST_DATA;
         end
         ST_DATA:  if (at_last && (b == 3'd7)) state_nx = ST_STOP;
         ST_STOP:  if (at_vote) state_nx = vote ? ST_IDLE : ST_BREAK;
         ST_BREAK: if (rxs) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // frame datapath: sample/bit counters, vote samples, shifter and outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         s         <= '0;
         b         <= '0;
         smp       <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state    <= state_nx;
         rx_busy  <= (state_nx != ST_IDLE);
         rx_valid <= 1'b0;
         if (state == ST_IDLE) begin
            s <= '0;
            b <= '0;
         end else if (tick) begin
            s <= s + 4'd1;
            if (s == VOTE_S0) smp[0] <= rxs;
            if (s == VOTE_S1) smp[1] <= rxs;
            if ((state == ST_DATA) && (s == VOTE_S2)) shreg <= {vote, shreg[7:1]};
            if ((state == ST_DATA) && (s == LAST_S))  b <= b + 3'd1;
            if ((state == ST_STOP) && (s == VOTE_S2)) begin
               if (vote) begin
                  rx_data   <= shreg;
                  rx_valid  <= 1'b1;
                  frame_err <= 1'b0;
               end else begin
                  frame_err <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_rx.sv
// Randomised scoreboard bench for serial_rx. The stimulus side builds 8N1
// frames from bytes and pushes every byte that should be delivered; an
// independent monitor pops on each rx_valid strobe.
module tb_serial_rx;

   localparam int CLK_FREQ = 12_800_000;
   localparam int BAUD     = 100_000;
   localparam int DIV      = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
   localparam int BIT      = 16 * DIV;
   localparam int BIT_SLOW = (BIT * 103) / 100;
   localparam int BIT_FAST = (BIT * 97) / 100;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_in = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;

   serial_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_in     (rx_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_busy   (rx_busy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         n_valid = 0;
   logic [7:0] exp_q[$];
   int         t_valid[$];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // monitor: every strobe must match the oldest byte still owed
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rx_valid === 1'b1) begin
            n_valid++;
            t_valid.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_valid: got rx_data %0h, expected no strobe", rx_data);
            end else begin
               e = exp_q.pop_front();
               check("rx_data", rx_data, e);
               check("frame_err_on_valid", frame_err, 1'b0);
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // drives one frame; optional single-clock spike and optional reset abort
   task automatic send_frame(input logic [7:0] d, input int bclk, input logic stop_v,
                             input int spike_bit, input int spike_off, input int abort_bit);
      logic [9:0] fr;
      fr = {stop_v, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < bclk; j++) begin
            @(negedge clk);
            if (i == abort_bit && j == bclk / 2) begin
               reset = 1'b0;
               repeat (3) @(negedge clk);
               check("abort_rx_data", rx_data, 8'h00);
               check("abort_rx_busy", rx_busy, 1'b0);
               check("abort_rx_valid", rx_valid, 1'b0);
               rx_in = 1'b1;
               repeat (5) @(negedge clk);
               reset = 1'b1;
               return;
            end
            rx_in = fr[i] ^ ((i == spike_bit) && (j == spike_off));
         end
      end
   endtask

   task automatic good(input logic [7:0] d, input int bclk);
      exp_q.push_back(d);
      send_frame(d, bclk, 1'b1, -1, 0, -1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (rx_busy !== 1'b0 && n < 4 * BIT) begin
         @(negedge clk);
         n++;
      end
      check(name, rx_busy, 1'b0);
   endtask

   initial begin
      int base;
      int gap;
      int n;
      int vcount;
      logic [7:0] d;
      int bc;

      repeat (4) @(negedge clk);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_rx_busy", rx_busy, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      reset = 1'b1;
      repeat (20) @(negedge clk);

      good(8'hA5, BIT);
      wait_idle("a5_idle");
      check("a5_frame_err", frame_err, 1'b0);
      check("a5_rx_data", rx_data, 8'hA5);
      check("a5_drained", exp_q.size(), 0);

      base = t_valid.size();
      good(8'h00, BIT);
      good(8'hFF, BIT);
      repeat (BIT) @(negedge clk);
      check("b2b_count", t_valid.size() - base, 2);
      if (t_valid.size() - base == 2) begin
         gap = t_valid[base + 1] - t_valid[base];
         check("b2b_gap_in_range", (gap >= 10 * BIT - 8) && (gap <= 10 * BIT + 8), 1'b1);
      end

      vcount = n_valid;
      send_frame(8'h3C, BIT, 1'b0, -1, 0, -1);
      rx_in = 1'b1;
      repeat (BIT) @(negedge clk);
      check("ferr_set", frame_err, 1'b1);
      check("ferr_data_kept", rx_data, 8'hFF);
      check("ferr_no_valid", n_valid, vcount);
      check("ferr_busy", rx_busy, 1'b0);
      good(8'h12, BIT);
      repeat (BIT / 2) @(negedge clk);
      check("ferr_cleared", frame_err, 1'b0);
      check("after_ferr_data", rx_data, 8'h12);

      vcount = n_valid;
      rx_in = 1'b0;
      repeat (24) @(negedge clk);
      rx_in = 1'b1;
      check("glitch_busy_high", rx_busy, 1'b1);
      n = 0;
      while (rx_busy !== 1'b0 && n < 4 * BIT) begin
         @(negedge clk);
         n++;
      end
      check("glitch_busy_low", rx_busy, 1'b0);
      check("glitch_fast_reject", n <= 12 * DIV, 1'b1);
      repeat (BIT) @(negedge clk);
      check("glitch_no_valid", n_valid, vcount);
      check("glitch_frame_err", frame_err, 1'b0);

      exp_q.push_back(8'h01);
      send_frame(8'h01, BIT, 1'b1, 1, 9 * DIV, -1);
      repeat (BIT) @(negedge clk);
      check("spike_data", rx_data, 8'h01);

      vcount = n_valid;
      send_frame(8'h5A, BIT, 1'b1, -1, 0, 5);
      repeat (2 * BIT) @(negedge clk);
      check("abort_no_valid", n_valid, vcount);
      check("abort_data_after", rx_data, 8'h00);
      good(8'hC3, BIT);
      repeat (BIT) @(negedge clk);
      check("post_abort_data", rx_data, 8'hC3);
      check("post_abort_count", n_valid, vcount + 1);

      good(8'h55, BIT_SLOW);
      repeat (BIT) @(negedge clk);
      check("slow_baud_data", rx_data, 8'h55);
      good(8'h55, BIT_FAST);
      repeat (BIT) @(negedge clk);
      check("fast_baud_data", rx_data, 8'h55);

      for (int k = 0; k < 12; k++) begin
         d  = 8'($urandom);
         bc = $urandom_range(BIT_FAST, BIT_SLOW);
         good(d, bc);
         repeat ($urandom_range(0, 64)) @(negedge clk);
      end

      repeat (2 * BIT) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      check("final_frame_err", frame_err, 1'b0);
      check("final_busy", rx_busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
UART receiver; the receive-side counterpart of the board's serial TX path (ADC value -> PC).
Recovers 8N1 bytes from the PC on rx_in using 16x oversampling with 3-sample majority vote at mid-bit.
Presents each good byte on rx_data with a one-cycle rx_valid strobe.
Downstream logic (ADC channel select, LED display) consumes the byte.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, serial bit rate
DIV, (CLK_FREQ + BAUD*8)/(BAUD*16), clocks per oversample tick (rounded); 326 at defaults

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  asynchronous, active-low reset
rx_in  input  1  serial line, idle high, asynchronous to clk
rx_data  output  8  last correctly received byte, LSB first on the line
rx_valid  output  1  one-clk pulse when rx_data updates
rx_busy  output  1  high while a frame is in progress (state != IDLE)
frame_err  output  1  sticky: last frame had stop bit = 0; cleared by the next good frame

Behaviour:
- Reset (reset=0, async): state=IDLE; all counters 0; sync flops=1; rx_data=8'h00; rx_valid=0; rx_busy=0; frame_err=0.
- Input sync: 2-FF synchronizer on rx_in; all logic uses synced value rxs.
- Tick generator: counter 0..DIV-1; tick=1 for one clk when counter==DIV-1, then wraps to 0. Counter is forced to 0 on the IDLE->START transition so ticks are phase-aligned to the start edge.
- Sample counter s (4 bits) counts ticks within a bit, 0..15; bit counter b (3 bits).
- Majority vote: rxs is captured on ticks at s=7, 8 and 9. The bit value is the majority of the 3 samples, decided at the s=9 tick.
- State machine:
  - IDLE: on rxs==0 go START; s=0.
  - START: at the vote (s=9): voted 1 -> false start, return to IDLE with no flags changed; voted 0 -> continue. At s=15 tick go DATA with s=0, b=0.
  - DATA: at each vote, shift the voted bit into shreg MSB (shift right), so the first received bit ends in bit 0. At s=15 tick: if b==7 go STOP, else b=b+1. s wraps to 0.
  - STOP, vote = 1: rx_data<=shreg, rx_valid=1 for exactly one clk, frame_err<=0, go IDLE immediately, without waiting out the rest of the stop bit, so back-to-back frames are caught.
  - STOP, vote = 0: frame_err<=1, rx_data unchanged, no rx_valid, go BREAK.
  - BREAK: wait until rxs==1, then IDLE. A held-low line (break) yields exactly one frame_err and no spurious frames.
- Latency: rx_valid asserts on the clk after the stop-bit s=9 tick, about 9.5 bit times after the start edge, plus 2 clks of synchronizer delay.
- rx_busy = (state != IDLE), registered.
- Reset mid-frame: async abort to IDLE; the partial byte is discarded; rx_data returns to 0.
- Glitch shorter than half a bit on an idle line: rejected as a false start.
- Baud tolerance: frames within +/-3% of BAUD must decode correctly.

Decomposition:
- Package serial_rx_pkg:
  - state enum IDLE/START/DATA/STOP/BREAK (3-bit)
  - OVERSAMPLE=16, VOTE_S0=7, VOTE_S1=8, VOTE_S2=9, LAST_S=15
- Sub-module serial_rx_baud_tick:
  - ports: clk, reset, clr, tick
  - parameter DIV
  - holds the divider counter

Test Plan:
- Default params (bit = 5216 clk): send 8'hA5 (start, 1,0,1,0,0,1,0,1, stop) -> one rx_valid pulse, rx_data=8'hA5, frame_err=0, rx_busy low after.
- Back-to-back 8'h00 then 8'hFF, no idle gap -> two rx_valid pulses about 10 bit times apart, data 00 then FF.
- Stop bit driven 0 on byte 8'h3C, then line high -> frame_err=1, no rx_valid, rx_data keeps the previous value. Next good byte 8'h12 -> frame_err=0, rx_data=8'h12.
- Idle line, 1000-clk low glitch -> no rx_valid, rx_busy returns to 0 after about 8 ticks, state IDLE.
- Single-clk low spike at the s=8 sample point of data bit 0 of 8'h01 -> majority vote yields 8'h01.
- Assert reset low mid data bit 4 of 8'h5A, release, then send 8'hC3 -> rx_data=00 during reset, then 8'hC3 with a single rx_valid.
- BAUD sweep at 9312 and 9888 (+/-3%), sending 8'h55 -> decoded correctly.
